vga_timing_gen: RTL

// Parametrised VGA/DVI raster timing generator; next generation of the fixed 640x480 controller.
// - Timing is set per axis by parameters; the pixel-clock divider and sync polarity are configurable.
// - All outputs are registered and aligned to the same pixel.
// - Adds line_start/frame_start strobes, an enable, and a look-ahead fetch coordinate for framebuffer reads with latency.
// - Sits between the system clock and the pixel pipeline (framebuffer reader, colour mux, RGB pins).

---
 rtl/vga_timing_pkg.sv | 56 +++++
 rtl/vga_axis_counter.sv | 73 +++++++
 rtl/vga_timing_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing types, mode presets and helpers for the VGA/DVI raster generator.
// Each raster axis is display, front porch, sync, back porch in that order.
package vga_timing_pkg;

   localparam int CNT_W_DEFAULT = 10;

   typedef struct packed {
      int d;
      int f;
      int s;
      int b;
      bit pol;
   } axis_timing_t;

   typedef struct packed {
      axis_timing_t h;
      axis_timing_t v;
   } mode_timing_t;

   typedef enum logic [1:0] {
      REG_DISPLAY = 2'd0,
      REG_FRONT   = 2'd1,
      REG_SYNC    = 2'd2,
      REG_BACK    = 2'd3
   } axis_region_e;

   localparam mode_timing_t VGA_640x480_60 = '{
      h: '{d: 640, f: 16, s: 96,  b: 48, pol: 1'b0},
      v: '{d: 480, f: 10, s: 2,   b: 33, pol: 1'b0}
   };

   localparam mode_timing_t SVGA_800x600_60 = '{
      h: '{d: 800, f: 40, s: 128, b: 88, pol: 1'b1},
      v: '{d: 600, f: 1,  s: 4,   b: 23, pol: 1'b1}
   };

   function automatic int total(input int d, input int f, input int s, input int b);
      return d + f + s + b;
   endfunction

   function automatic axis_region_e region_of(input int pos, input int d, input int f,
                                              input int s);
      axis_region_e r;
      if (pos < d) begin
         r = REG_DISPLAY;
      end else if (pos < d + f) begin
         r = REG_FRONT;
      end else if (pos < d + f + s) begin
         r = REG_SYNC;
      end else begin
         r = REG_BACK;
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decodes of the value it takes on the
// coming edge, so the parent can register them in step with the counter itself.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int D   = 640,
   parameter int F   = 16,
   parameter int S   = 96,
   parameter int B   = 48,
   parameter bit POL = 1'b0,
   parameter int W   = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic [W-1:0] init_val,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   localparam int           TOTAL = total(D, F, S, B);
   localparam logic [W-1:0] LAST  = W'(TOTAL - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   axis_region_e region_s;

   assign wrap  = (count_q == LAST);
   assign count = count_d;

   // next position and the region decode of that next position
   always_comb begin
      count_d  = count_q;
      active   = 1'b0;
      sync     = ~POL;
      if (step) begin
         if (wrap) begin
            count_d = '0;
         end else begin
            count_d = count_q + W'(1);
         end
      end else begin
         count_d = count_q;
      end
      region_s = region_of(int'(count_d), D, F, S);
      case (region_s)
         REG_DISPLAY: begin
            active = 1'b1;
            sync   = ~POL;
         end
         REG_SYNC: begin
            active = 1'b0;
            sync   = POL;
         end
         default: begin
            active = 1'b0;
            sync   = ~POL;
         end
      endcase
   end

   // position register; reset loads the caller-chosen start point
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= init_val;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with pixel-clock divider, line/frame
// strobes and a look-ahead fetch coordinate for framebuffer reads with latency.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = VGA_640x480_60.h.d,
   parameter int H_FRONT   = VGA_640x480_60.h.f,
   parameter int H_SYNC    = VGA_640x480_60.h.s,
   parameter int H_BACK    = VGA_640x480_60.h.b,
   parameter int V_DISPLAY = VGA_640x480_60.v.d,
   parameter int V_FRONT   = VGA_640x480_60.v.f,
   parameter int V_SYNC    = VGA_640x480_60.v.s,
   parameter int V_BACK    = VGA_640x480_60.v.b,
   parameter bit HS_POL    = VGA_640x480_60.h.pol,
   parameter bit VS_POL    = VGA_640x480_60.v.pol,
   parameter int CLK_DIV   = 2,
   parameter int LOOKAHEAD = 2,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic             pixel_tick,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] x_o,
   output logic [CNT_W-1:0] y_o,
   output logic             line_start,
   output logic             frame_start,
   output logic [CNT_W-1:0] fetch_x,
   output logic [CNT_W-1:0] fetch_y,
   output logic             fetch_valid
);

   localparam int H_TOTAL = total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   // fetch counters start LOOKAHEAD pixels ahead of the (H_TOTAL-1, V_TOTAL-1) reset point
   localparam int FH_INIT = (LOOKAHEAD == 0) ? H_TOTAL - 1 : LOOKAHEAD - 1;
   localparam int FV_INIT = (LOOKAHEAD == 0) ? V_TOTAL - 1 : 0;

   if (longint'(MAX_TOTAL - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
      $error("vga_timing_gen: CNT_W too narrow for the raster totals");
   end
   if (CLK_DIV < 1) begin : g_div_check
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if ((LOOKAHEAD < 0) || (LOOKAHEAD > H_TOTAL - 1)) begin : g_la_check
      $error("vga_timing_gen: LOOKAHEAD out of range");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_s;
   logic [CNT_W-1:0] h_cnt_s, v_cnt_s, fh_cnt_s, fv_cnt_s;
   logic             h_wrap_s, v_wrap_s, fh_wrap_s, fv_wrap_unused;
   logic             h_act_s, v_act_s, fh_act_s, fv_act_s;
   logic             h_sync_s, v_sync_s, fh_sync_unused, fv_sync_unused;

   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic [CNT_W-1:0] x_o_q, x_o_d;
   logic [CNT_W-1:0] y_o_q, y_o_d;
   logic             line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;
   logic [CNT_W-1:0] fetch_x_q, fetch_x_d;
   logic [CNT_W-1:0] fetch_y_q, fetch_y_d;
   logic             fetch_valid_q, fetch_valid_d;

   assign tick_s     = en && !reset && (div_q == DIV_LAST);
   assign pixel_tick = tick_s;

   vga_axis_counter #(.D(H_DISPLAY), .F(H_FRONT), .S(H_SYNC), .B(H_BACK), .POL(HS_POL),
                      .W(CNT_W)) u_h_cnt (
      .clk(clk), .rst(reset), .step(tick_s), .init_val(CNT_W'(H_TOTAL - 1)),
      .count(h_cnt_s), .wrap(h_wrap_s), .active(h_act_s), .sync(h_sync_s)
   );

   vga_axis_counter #(.D(V_DISPLAY), .F(V_FRONT), .S(V_SYNC), .B(V_BACK), .POL(VS_POL),
                      .W(CNT_W)) u_v_cnt (
      .clk(clk), .rst(reset), .step(tick_s && h_wrap_s), .init_val(CNT_W'(V_TOTAL - 1)),
      .count(v_cnt_s), .wrap(v_wrap_s), .active(v_act_s), .sync(v_sync_s)
   );

   vga_axis_counter #(.D(H_DISPLAY), .F(H_FRONT), .S(H_SYNC), .B(H_BACK), .POL(HS_POL),
                      .W(CNT_W)) u_fh_cnt (
      .clk(clk), .rst(reset), .step(tick_s), .init_val(CNT_W'(FH_INIT)),
      .count(fh_cnt_s), .wrap(fh_wrap_s), .active(fh_act_s), .sync(fh_sync_unused)
   );

   vga_axis_counter #(.D(V_DISPLAY), .F(V_FRONT), .S(V_SYNC), .B(V_BACK), .POL(VS_POL),
                      .W(CNT_W)) u_fv_cnt (
      .clk(clk), .rst(reset), .step(tick_s && fh_wrap_s), .init_val(CNT_W'(FV_INIT)),
      .count(fv_cnt_s), .wrap(fv_wrap_unused), .active(fv_act_s), .sync(fv_sync_unused)
   );

   // divider step and output decodes, loaded only on the tick that moves the counters
   always_comb begin
      div_d         = div_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      x_o_d         = x_o_q;
      y_o_d         = y_o_q;
      line_start_d  = line_start_q;
      frame_start_d = frame_start_q;
      fetch_x_d     = fetch_x_q;
      fetch_y_d     = fetch_y_q;
      fetch_valid_d = fetch_valid_q;
      if (tick_s) begin
         div_d         = '0;
         hsync_d       = h_sync_s;
         vsync_d       = v_sync_s;
         video_on_d    = h_act_s && v_act_s;
         x_o_d         = h_cnt_s;
         y_o_d         = v_cnt_s;
         line_start_d  = h_wrap_s;
         frame_start_d = h_wrap_s && v_wrap_s;
         fetch_x_d     = fh_cnt_s;
         fetch_y_d     = fv_cnt_s;
         fetch_valid_d = fh_act_s && fv_act_s;
      end else if (en) begin
         div_d = div_q + DIV_W'(1);
      end else begin
         div_d = div_q;
      end
   end

   // divider and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q         <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         video_on_q    <= 1'b0;
         x_o_q         <= '0;
         y_o_q         <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         fetch_x_q     <= '0;
         fetch_y_q     <= '0;
         fetch_valid_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         x_o_q         <= x_o_d;
         y_o_q         <= y_o_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         fetch_x_q     <= fetch_x_d;
         fetch_y_q     <= fetch_y_d;
         fetch_valid_q <= fetch_valid_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign x_o         = x_o_q;
   assign y_o         = y_o_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign fetch_x     = fetch_x_q;
   assign fetch_y     = fetch_y_q;
   assign fetch_valid = fetch_valid_q;

endmodule
